// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// bus widths, the default RAM access length, the FSM state type and
// the wait-counter load helper.
package mem_arbiter_pkg;

  localparam int unsigned REG_BUS             = 32;
  localparam int unsigned INST_ADDR_BUS       = 32;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
  localparam int unsigned WAIT_CNT_W          = 3;

  typedef logic [REG_BUS-1:0]       reg_bus_t;
  typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
  typedef logic [WAIT_CNT_W-1:0]    wait_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_e;

  // Value loaded into the wait counter on a grant; the access completes
  // when the counter has run down to zero.
  function automatic wait_cnt_t wait_load(input int unsigned wait_cycles);
    return wait_cnt_t'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's handshake and RAM signals.
//   inst_*  : fetch request/address in, fetched word and ack out
//   data_*  : MEM-stage request, write flag, lanes, address, store data in;
//             load word and ack out
//   ram_*   : shared single-port RAM (strobes/address/data out, read data in)
//   stallreq_o : pipeline stall request
// Modport slave is the arbiter's view; master is the pipeline/RAM side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic       inst_req_i;
  inst_addr_t inst_addr_i;
  reg_bus_t   inst_rdata_o;
  logic       inst_ack_o;

  logic       data_ce_i;
  logic       data_wr_i;
  logic [3:0] data_sel_i;
  reg_bus_t   data_addr_i;
  reg_bus_t   data_wdata_i;
  reg_bus_t   data_rdata_o;
  logic       data_ack_o;

  logic       ram_ce_o;
  logic       ram_we_o;
  logic [3:0] ram_sel_o;
  reg_bus_t   ram_addr_o;
  reg_bus_t   ram_wdata_o;
  reg_bus_t   ram_rdata_i;

  logic       stallreq_o;

  modport slave (
    input  inst_req_i, inst_addr_i,
    output inst_rdata_o, inst_ack_o,
    input  data_ce_i, data_wr_i, data_sel_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_ack_o,
    output ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    output stallreq_o
  );

  modport master (
    output inst_req_i, inst_addr_i,
    input  inst_rdata_o, inst_ack_o,
    output data_ce_i, data_wr_i, data_sel_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_ack_o,
    input  ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    input  stallreq_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and the
// MEM stage. Each grant holds the RAM strobes for WAIT_CYCLES cycles,
// captures the read word at the end and pulses the requester's ack for one
// cycle. Contention is resolved by alternating on the last data grant.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (fetch, data, RAM and stall signals)
// Parameter:
//   WAIT_CYCLES : RAM access cycles per transaction, 1..7
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam wait_cnt_t CNT_LOAD = wait_load(WAIT_CYCLES);

  arb_state_e state;
  wait_cnt_t  cnt;
  logic       last_d;
  logic       rst_done;

  logic       grant_d;
  logic       grant_i;

  logic       inst_ack_q;
  logic       data_ack_q;
  reg_bus_t   inst_rdata_q;
  reg_bus_t   data_rdata_q;
  logic       ram_ce_q;
  logic       ram_we_q;
  logic [3:0] ram_sel_q;
  reg_bus_t   ram_addr_q;
  reg_bus_t   ram_wdata_q;

  // Grant decode and stall request. Grants are only considered in IDLE,
  // so requester inputs are ignored for the whole of an access.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE && rst_done) begin
      if (bus.data_ce_i && (!bus.inst_req_i || !last_d)) begin
        grant_d = 1'b1;
      end else if (bus.inst_req_i) begin
        grant_i = 1'b1;
      end
    end
    bus.stallreq_o = (bus.data_ce_i & ~data_ack_q) | (bus.inst_req_i & ~inst_ack_q);
  end

  // rst_done holds off the first grant until the second edge after reset
  // release, so a release close to an edge never launches a RAM access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_d       <= 1'b0;
      rst_done     <= 1'b0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_sel_q    <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      rst_done   <= 1'b1;
      inst_ack_q <= 1'b0;
      data_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= GNT_D;
            cnt         <= CNT_LOAD;
            last_d      <= 1'b1;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= bus.data_wr_i;
            ram_sel_q   <= bus.data_sel_i;
            ram_addr_q  <= bus.data_addr_i;
            ram_wdata_q <= bus.data_wdata_i;
          end else if (grant_i) begin
            state       <= GNT_I;
            cnt         <= CNT_LOAD;
            last_d      <= 1'b0;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= '1;
            ram_addr_q  <= bus.inst_addr_i;
            ram_wdata_q <= '0;
          end
        end
        GNT_D: begin
          if (cnt == '0) begin
            // Stores leave the load register untouched.
            if (!ram_we_q) begin
              data_rdata_q <= bus.ram_rdata_i;
            end
            data_ack_q <= 1'b1;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GNT_I: begin
          if (cnt == '0) begin
            inst_rdata_q <= bus.ram_rdata_i;
            inst_ack_q   <= 1'b1;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_ack_o   = inst_ack_q;
  assign bus.inst_rdata_o = inst_rdata_q;
  assign bus.data_ack_o   = data_ack_q;
  assign bus.data_rdata_o = data_rdata_q;
  assign bus.ram_ce_o     = ram_ce_q;
  assign bus.ram_we_o     = ram_we_q;
  assign bus.ram_sel_o    = ram_sel_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (WAIT_CYCLES = 2 and 1)
// sharing one behavioural RAM. Expected data comes from a word-level memory
// model, arbitration order from the alternation rule on the last data grant.
module tb_mem_arbiter;

  localparam int unsigned W1 = 2;
  localparam int unsigned W2 = 1;
  localparam int unsigned BOUND = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus2 ();

  mem_arbiter #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_arbiter #(.WAIT_CYCLES(W2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- memory models ----------------
  logic [31:0] ram     [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];

  function automatic logic [31:0] seed(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : seed(a);
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : seed(a);
  endfunction

  // RAM: writes while strobed, read data valid half a cycle after address.
  always @(negedge clk) begin
    if (bus1.ram_ce_o && bus1.ram_we_o)
      ram[bus1.ram_addr_o] = lanes(rd_ram(bus1.ram_addr_o), bus1.ram_wdata_o, bus1.ram_sel_o);
    bus1.ram_rdata_i = rd_ram(bus1.ram_addr_o);
    bus2.ram_rdata_i = rd_ram(bus2.ram_addr_o);
  end

  // ---------------- per-cycle monitor ----------------
  int unsigned ce_run [2];
  int unsigned we_run [2];
  logic        dack_prev [2];
  logic        iack_prev [2];

  task automatic mon(input int id, input int unsigned w, input logic ce, input logic we,
                     input logic stall, input logic dce, input logic dack,
                     input logic ireq, input logic iack);
    check($sformatf("stall%0d", id), stall, (dce & ~dack) | (ireq & ~iack));
    if (!rst) begin
      ce_run[id] = 0; we_run[id] = 0; dack_prev[id] = 1'b0; iack_prev[id] = 1'b0;
      return;
    end
    if (ce) ce_run[id]++;
    else if (ce_run[id] != 0) begin
      check($sformatf("ce_len%0d", id), ce_run[id], w); ce_run[id] = 0;
    end
    if (we) we_run[id]++;
    else if (we_run[id] != 0) begin
      check($sformatf("we_len%0d", id), we_run[id], w); we_run[id] = 0;
    end
    if (dack_prev[id]) check($sformatf("dack_pulse%0d", id), dack, 1'b0);
    if (iack_prev[id]) check($sformatf("iack_pulse%0d", id), iack, 1'b0);
    dack_prev[id] = dack;
    iack_prev[id] = iack;
  endtask

  always @(negedge clk) begin
    mon(0, W1, bus1.ram_ce_o, bus1.ram_we_o, bus1.stallreq_o, bus1.data_ce_i,
        bus1.data_ack_o, bus1.inst_req_i, bus1.inst_ack_o);
    mon(1, W2, bus2.ram_ce_o, bus2.ram_we_o, bus2.stallreq_o, bus2.data_ce_i,
        bus2.data_ack_o, bus2.inst_req_i, bus2.inst_ack_o);
  end

  // ---------------- requester model (instance 1) ----------------
  logic        m_last_d;
  logic [31:0] exp_drd;
  logic [31:0] exp_ird;

  task automatic data_txn(input string tag, input logic wr, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int unsigned exp_lat, input logic solo);
    int unsigned n;
    n = 0;
    bus1.data_ce_i = 1'b1; bus1.data_wr_i = wr; bus1.data_sel_i = sel;
    bus1.data_addr_i = addr; bus1.data_wdata_i = wd;
    do begin @(posedge clk); #1; n++; end while (!bus1.data_ack_o && n < BOUND);
    check($sformatf("%s_lat", tag), n, exp_lat);
    if (!wr) exp_drd = rd_exp(addr);
    else exp_mem[addr] = lanes(rd_exp(addr), wd, sel);
    check($sformatf("%s_rdata", tag), bus1.data_rdata_o, exp_drd);
    if (solo) check($sformatf("%s_stall", tag), bus1.stallreq_o, 1'b0);
    bus1.data_ce_i = 1'b0; bus1.data_wr_i = 1'b0;
  endtask

  task automatic inst_txn(input string tag, input logic [31:0] addr,
                          input int unsigned exp_lat, input logic solo);
    int unsigned n;
    n = 0;
    bus1.inst_req_i = 1'b1; bus1.inst_addr_i = addr;
    do begin @(posedge clk); #1; n++; end while (!bus1.inst_ack_o && n < BOUND);
    check($sformatf("%s_lat", tag), n, exp_lat);
    exp_ird = rd_exp(addr);
    check($sformatf("%s_rdata", tag), bus1.inst_rdata_o, exp_ird);
    if (solo) check($sformatf("%s_stall", tag), bus1.stallreq_o, 1'b0);
    bus1.inst_req_i = 1'b0;
  endtask

  // Both requests raised together; winner follows the alternation rule, the
  // loser is granted one cycle after the winner's ack.
  task automatic both_txn(input string tag, input logic wr, input logic [3:0] sel,
                          input logic [31:0] daddr, input logic [31:0] wd,
                          input logic [31:0] iaddr, input int unsigned base);
    int unsigned lat_d, lat_i;
    if (m_last_d) begin
      lat_i = base; lat_d = base + W1 + 1; m_last_d = 1'b1;
    end else begin
      lat_d = base; lat_i = base + W1 + 1; m_last_d = 1'b0;
    end
    fork
      data_txn({tag, "_d"}, wr, sel, daddr, wd, lat_d, 1'b0);
      inst_txn({tag, "_i"}, iaddr, lat_i, 1'b0);
    join
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [31:0] a, wd;
    logic [3:0]  sel;
    int unsigned kind;

    {bus1.inst_req_i, bus1.data_ce_i, bus1.data_wr_i} = '0;
    {bus2.inst_req_i, bus2.data_ce_i, bus2.data_wr_i} = '0;
    bus1.inst_addr_i = '0; bus1.data_sel_i = '0; bus1.data_addr_i = '0; bus1.data_wdata_i = '0;
    bus2.inst_addr_i = '0; bus2.data_sel_i = '0; bus2.data_addr_i = '0; bus2.data_wdata_i = '0;
    ram[32'h100] = 32'hDEADBEEF;
    exp_mem[32'h100] = 32'hDEADBEEF;
    exp_drd = '0; exp_ird = '0; m_last_d = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", bus1.ram_ce_o, 1'b0);
    check("rst_we", bus1.ram_we_o, 1'b0);
    check("rst_sel", bus1.ram_sel_o, 4'h0);
    check("rst_addr", bus1.ram_addr_o, 32'h0);
    check("rst_wdata", bus1.ram_wdata_o, 32'h0);
    check("rst_dack", bus1.data_ack_o, 1'b0);
    check("rst_iack", bus1.inst_ack_o, 1'b0);
    check("rst_drd", bus1.data_rdata_o, 32'h0);
    check("rst_ird", bus1.inst_rdata_o, 32'h0);
    check("rst_ce2", bus2.ram_ce_o, 1'b0);
    rst = 1'b1;

    // Contention straight after reset: data first, first grant on 2nd edge
    both_txn("cont1", 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, W1 + 2);

    // Single load
    data_txn("load", 1'b0, 4'hF, 32'h100, 32'h0, W1 + 1, 1'b1);
    check("load_value", bus1.data_rdata_o, 32'hDEADBEEF);
    m_last_d = 1'b1;

    // Second contention round: instruction first
    both_txn("cont2", 1'b0, 4'hF, 32'h104, 32'h0, 32'h8, W1 + 1);

    // Byte store, then read back the merged word
    data_txn("bstore", 1'b1, 4'b0010, 32'h202, 32'hABABABAB, W1 + 1, 1'b1);
    data_txn("bstore_rd", 1'b0, 4'hF, 32'h202, 32'h0, W1 + 1, 1'b1);
    check("bstore_lane", bus1.data_rdata_o, lanes(seed(32'h202), 32'hABABABAB, 4'b0010));

    // Store with no lanes enabled
    data_txn("nolane", 1'b1, 4'b0000, 32'h44, 32'h12345678, W1 + 1, 1'b1);
    data_txn("nolane_rd", 1'b0, 4'hF, 32'h44, 32'h0, W1 + 1, 1'b1);
    check("nolane_val", bus1.data_rdata_o, seed(32'h44));
    m_last_d = 1'b1;

    // Fetch dropped after grant still completes
    bus1.inst_req_i = 1'b1; bus1.inst_addr_i = 32'h30;
    @(posedge clk); #1;
    bus1.inst_req_i = 1'b0;
    n = 1;
    do begin @(posedge clk); #1; n++; end while (!bus1.inst_ack_o && n < BOUND);
    check("drop_lat", n, W1 + 1);
    exp_ird = rd_exp(32'h30);
    check("drop_rdata", bus1.inst_rdata_o, exp_ird);
    m_last_d = 1'b0;

    // Reset during the first cycle of an instruction access
    idle(1);
    bus1.inst_req_i = 1'b1; bus1.inst_addr_i = 32'h50;
    @(posedge clk); #1;
    check("abort_ce_before", bus1.ram_ce_o, 1'b1);
    check("abort_sel", bus1.ram_sel_o, 4'hF);
    check("abort_we", bus1.ram_we_o, 1'b0);
    check("abort_addr", bus1.ram_addr_o, 32'h50);
    #2 rst = 1'b0;
    #1 check("abort_ce_async", bus1.ram_ce_o, 1'b0);
    bus1.inst_req_i = 1'b0;
    exp_ird = '0; exp_drd = '0; m_last_d = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_ack", bus1.inst_ack_o, 1'b0);
    end
    rst = 1'b1;
    check("abort_ird_clr", bus1.inst_rdata_o, 32'h0);
    inst_txn("refetch", 32'h50, W1 + 2, 1'b1);

    // Back-to-back fetches with single-cycle access on instance 2
    bus2.inst_req_i = 1'b1; bus2.inst_addr_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus2.inst_ack_o && n < BOUND);
      check($sformatf("b2b_lat%0d", k), n, 2);
      check($sformatf("b2b_rdata%0d", k), bus2.inst_rdata_o, rd_exp(32'(4 * k)));
      if (k < 2) bus2.inst_addr_i = 32'(4 * (k + 1));
      else bus2.inst_req_i = 1'b0;
    end

    // Randomized mix on instance 1
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      a    = 32'h40 + 32'(4 * $urandom_range(0, 7));
      wd   = $urandom;
      sel  = 4'($urandom);
      case (kind)
        0: begin data_txn("rnd_ld", 1'b0, 4'hF, a, 32'h0, W1 + 1, 1'b1); m_last_d = 1'b1; end
        1: begin data_txn("rnd_st", 1'b1, sel, a, wd, W1 + 1, 1'b1); m_last_d = 1'b1; end
        2: begin inst_txn("rnd_if", a, W1 + 1, 1'b1); m_last_d = 1'b0; end
        default: both_txn("rnd_both", 1'($urandom_range(0, 1)), sel, a, wd,
                          32'h40 + 32'(4 * $urandom_range(0, 7)), W1 + 1);
      endcase
      idle($urandom_range(0, 2));
      check("hold_ird", bus1.inst_rdata_o, exp_ird);
      check("hold_drd", bus1.data_rdata_o, exp_drd);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, RAM access cycles per transaction; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 inst_req_i  in  1 / inst_addr_i  in  32  fetch request and word address from IF.
REQ-005 inst_rdata_o  out  32 / inst_ack_o  out  1  fetched word; one-cycle completion pulse.
REQ-006 data_ce_i  in  1 / data_wr_i  in  1 / data_sel_i  in  4  MEM-stage request, write flag, byte lanes (bit3 = bits 31:24).
REQ-007 data_addr_i  in  32 / data_wdata_i  in  32  MEM-stage address and lane-replicated store data.
REQ-008 data_rdata_o  out  32 / data_ack_o  out  1  raw load word, unextended; one-cycle completion pulse.
REQ-009 ram_ce_o  out  1 / ram_we_o  out  1 / ram_sel_o  out  4 / ram_addr_o  out  32 / ram_wdata_o  out  32 / ram_rdata_i  in  32  shared single-port RAM.
REQ-010 stallreq_o  out  1  pipeline stall request to the stall controller.

Function
REQ-011 The FSM SHALL have states IDLE, GNT_D (data access) and GNT_I (instruction access).
REQ-012 In IDLE, if exactly one request is pending, the FSM SHALL grant it on the next edge.
REQ-013 If both requests are pending in IDLE, grant SHALL go to data unless last_d = 1, in which case it SHALL go to instruction.
REQ-014 last_d SHALL be set on every data grant and cleared on every instruction grant.
REQ-015 On grant, the arbiter SHALL register the granted requester's address, sel, wdata and write flag into the ram_* outputs.
REQ-016 Instruction grants SHALL drive ram_we_o = 0 and ram_sel_o = 4'b1111.
REQ-017 ram_ce_o SHALL be 1 for exactly WAIT_CYCLES consecutive cycles per grant.
REQ-018 For a data write, ram_we_o SHALL be 1 for the same WAIT_CYCLES cycles.
REQ-019 ram_* outputs SHALL hold stable for the whole access.
REQ-020 A 3-bit counter SHALL load WAIT_CYCLES-1 on grant and decrement each cycle in GNT_x.
REQ-021 When the counter reaches 0: capture ram_rdata_i into the granted rdata register, pulse the matching ack for one cycle and return to IDLE.
REQ-022 Whenever the FSM is in IDLE, ram_ce_o and ram_we_o SHALL be 0.
REQ-023 Grant-to-ack latency SHALL be WAIT_CYCLES+1 cycles, and ack-to-next-grant latency SHALL be 1 cycle.
REQ-024 stallreq_o SHALL equal (data_ce_i & ~data_ack_o) | (inst_req_i & ~inst_ack_o), combinationally.
REQ-025 inst_rdata_o and data_rdata_o SHALL hold their last captured value until the next completion on the same port.
REQ-026 Requesters hold request inputs stable until ack; the arbiter SHALL NOT sample inputs while in GNT_x.
REQ-027 A request dropped before ack SHALL still complete its RAM access; the ack is still issued and is ignored.
REQ-028 data_ce_i with data_sel_i = 0 SHALL complete as a normal access, with no lanes written.

Reset
REQ-029 On rst low, immediately: FSM = IDLE; counter, last_d and all ram_* outputs = 0.
REQ-030 On rst low, immediately: both acks = 0 and both rdata registers = 32'h0.
REQ-031 Reset mid-access SHALL abort the access with no ack.
REQ-032 The first grant after reset release SHALL occur no earlier than the second rising edge.

Structure
REQ-033 The state encoding and the WAIT_CYCLES default SHALL live in the shared defines file alongside the existing bus-width macros.
REQ-034 The 32-bit widths SHALL reuse the existing RegBus and InstAddrBus macros.
REQ-035 The block SHALL be a single module with no sub-modules.
REQ-036 The counter and FSM SHALL be in one sequential process; the output decode SHALL be in one combinational process.

Verification
REQ-037 Single load: data_ce_i=1, data_addr_i=0x100, RAM returns 0xDEADBEEF, WAIT_CYCLES=2 -> ram_ce_o high 2 cycles, data_ack_o on cycle 3, data_rdata_o=0xDEADBEEF, stallreq_o low in the ack cycle.
REQ-038 Contention: both requests raised in the same cycle after reset -> data granted first, instruction granted 1 cycle after data_ack_o.
REQ-039 Contention, second round: both raised again -> instruction granted first.
REQ-040 Byte store: data_wr_i=1, data_sel_i=4'b0010, data_wdata_i=0xABABABAB, addr 0x202 -> ram_we_o=1, ram_sel_o=0010 for exactly WAIT_CYCLES cycles; no data_rdata_o change.
REQ-041 Reset mid-access: rst low during cycle 1 of GNT_I -> ram_ce_o drops asynchronously, no inst_ack_o.
REQ-042 Reset mid-access, after release: re-issued fetch completes normally.
REQ-043 WAIT_CYCLES=1 back-to-back fetches to 0x0, 0x4, 0x8 -> ack every 2 cycles, correct data each.
REQ-044 Every bench SHALL check that stallreq_o matches REQ-024 on every cycle.
